// File: rtl/multdiv_sequencer_pkg.sv
// Shared processor constants for the multiply/divide sequencer.
//   OPC_RTYPE   : opcode field value of register-register instructions
//   ALU_MULT/DIV: ALU op field values that start a multiply or divide
//   ITER_COUNT  : number of radix-2 iterations per operation
//   md_state_t  : sequencer state encoding
package multdiv_sequencer_pkg;

   localparam logic [4:0] OPC_RTYPE  = 5'b00000;
   localparam logic [4:0] ALU_MULT   = 5'b00110;
   localparam logic [4:0] ALU_DIV    = 5'b00111;
   localparam int         ITER_COUNT = 32;
   localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   // Magnitude of a two's complement word; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// Radix-2 iteration datapath working on unsigned magnitudes.
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture load_a/load_b/load_is_div, clear the partial result
//   step         : perform one shift-add (mult) or restoring-divide (div) step
//   prod_next    : 64-bit {hi, lo} value after the current step (mult product)
//   quot_next    : low word after the current step (div quotient)
// The "next" outputs let the controller capture the finished value on the
// same edge that performs the final step.
module multdiv_iter_core (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic        load_is_div,
   input  logic [31:0] load_a,
   input  logic [31:0] load_b,
   output logic [63:0] prod_next,
   output logic [31:0] quot_next
);

   logic [31:0] hi_q, hi_d;     // partial product high word / remainder
   logic [31:0] lo_q, lo_d;     // multiplier shifting out / dividend->quotient
   logic [31:0] b_q, b_d;       // multiplicand / divisor magnitude
   logic        is_div_q, is_div_d;

   logic [31:0] step_hi, step_lo;
   logic [32:0] sum;
   logic [32:0] shifted;
   logic        rem_geq;
   logic [31:0] rem_sub;

   always_comb begin
      // Multiply: add multiplicand when the multiplier LSB is set, then
      // shift the 65-bit {carry, hi, lo} right by one.
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);

      // Divide: shift the next dividend bit into the remainder and try to
      // subtract. When the trial succeeds the true difference is below
      // 2^32, so a 32-bit subtract yields it exactly.
      shifted = {hi_q, lo_q[31]};
      rem_geq = (shifted >= {1'b0, b_q});
      rem_sub = shifted[31:0] - b_q;

      if (is_div_q) begin
         step_hi = rem_geq ? rem_sub : shifted[31:0];
         step_lo = {lo_q[30:0], rem_geq};
      end else begin
         step_hi = sum[32:1];
         step_lo = {sum[0], lo_q[31:1]};
      end

      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      is_div_d = is_div_q;
      if (load) begin
         hi_d     = '0;
         lo_d     = load_a;
         b_d      = load_b;
         is_div_d = load_is_div;
      end else if (step) begin
         hi_d = step_hi;
         lo_d = step_lo;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
      end
   end

   assign prod_next = {step_hi, step_lo};
   assign quot_next = step_lo;

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer for the DX pipeline stage.
//   clock, reset          : clock and asynchronous active-high reset
//   dx_ir_in              : DX instruction (opcode [31:27], rd [26:22], ALU op [6:2])
//   operand_a, operand_b  : signed rs / rt values
//   multdiv_is_running    : high for the 32 iteration cycles (pipeline stall)
//   multdiv_result_ready  : one-cycle pulse when the result is valid
//   multdiv_result        : product low word or truncated quotient
//   multdiv_exception     : overflow or divide-by-zero
//   multdiv_rd            : destination register of the completed operation
// The core iterates on magnitudes; sign and exception handling are applied
// here when the final iteration completes.
module multdiv_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dx_ir_in,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        multdiv_is_running,
   output logic        multdiv_result_ready,
   output logic [31:0] multdiv_result,
   output logic        multdiv_exception,
   output logic [4:0]  multdiv_rd
);

   import multdiv_sequencer_pkg::*;

   md_state_t   state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;           // result sign = sign(a) ^ sign(b)
   logic        div_zero_q, div_zero_d;
   logic        div_ovf_q, div_ovf_d;   // 0x80000000 / -1
   logic [4:0]  rd_q, rd_d;             // rd of the operation in flight
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;
   logic [4:0]  out_rd_q, out_rd_d;

   logic        start, start_is_div, accept, busy;
   logic [31:0] mag_a, mag_b;
   logic [63:0] core_prod, prod_signed;
   logic [31:0] core_quot, quot_signed;
   logic        mult_ovf;
   logic        ir_unused;

   assign ir_unused = ^{dx_ir_in[21:7], dx_ir_in[1:0]};

   multdiv_iter_core u_core (
      .clock       (clock),
      .reset       (reset),
      .load        (accept),
      .step        (busy),
      .load_is_div (start_is_div),
      .load_a      (mag_a),
      .load_b      (mag_b),
      .prod_next   (core_prod),
      .quot_next   (core_quot)
   );

   always_comb begin
      start        = (dx_ir_in[31:27] == OPC_RTYPE) &&
                     ((dx_ir_in[6:2] == ALU_MULT) || (dx_ir_in[6:2] == ALU_DIV));
      start_is_div = (dx_ir_in[6:2] == ALU_DIV);
      busy         = (state_q == ST_BUSY);
      accept       = start && !busy;
      mag_a        = abs32(operand_a);
      mag_b        = abs32(operand_b);

      prod_signed  = neg_q ? (64'd0 - core_prod) : core_prod;
      quot_signed  = neg_q ? (32'd0 - core_quot) : core_quot;
      // The product fits in 32 signed bits only if bits 63..31 all agree.
      mult_ovf     = !((&prod_signed[63:31]) || !(|prod_signed[63:31]));

      state_d    = state_q;
      count_d    = count_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      div_zero_d = div_zero_q;
      div_ovf_d  = div_ovf_q;
      rd_d       = rd_q;
      result_d   = result_q;
      exc_d      = exc_q;
      out_rd_d   = out_rd_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               state_d    = ST_BUSY;
               count_d    = '0;
               is_div_d   = start_is_div;
               neg_d      = operand_a[31] ^ operand_b[31];
               div_zero_d = (operand_b == 32'd0);
               div_ovf_d  = (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
               rd_d       = dx_ir_in[26:22];
            end
         end
         ST_BUSY: begin
            count_d = count_q + 5'd1;
            if (count_q == LAST_ITER) begin
               state_d  = ST_DONE;
               out_rd_d = rd_q;
               if (!is_div_q) begin
                  result_d = prod_signed[31:0];
                  exc_d    = mult_ovf;
               end else if (div_zero_q) begin
                  result_d = 32'd0;
                  exc_d    = 1'b1;
               end else if (div_ovf_q) begin
                  result_d = 32'h8000_0000;
                  exc_d    = 1'b1;
               end else begin
                  result_d = quot_signed;
                  exc_d    = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         div_zero_q <= 1'b0;
         div_ovf_q  <= 1'b0;
         rd_q       <= '0;
         result_q   <= '0;
         exc_q      <= 1'b0;
         out_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         div_zero_q <= div_zero_d;
         div_ovf_q  <= div_ovf_d;
         rd_q       <= rd_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
         out_rd_q   <= out_rd_d;
      end
   end

   assign multdiv_is_running   = (state_q == ST_BUSY);
   assign multdiv_result_ready = (state_q == ST_DONE);
   assign multdiv_result       = result_q;
   assign multdiv_exception    = exc_q;
   assign multdiv_rd           = out_rd_q;

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: dx_ir_in  input  32  DX-stage instruction; opcode [31:27], rd [26:22], ALU op [6:2].
REQ-004 SHALL have port: operand_a  input  32  DX-stage rs value, signed two's complement.
REQ-005 SHALL have port: operand_b  input  32  DX-stage rt value, signed two's complement.
REQ-006 SHALL have port: multdiv_is_running  output  1  high while an operation iterates; drives pipeline stall.
REQ-007 SHALL have port: multdiv_result_ready  output  1  one-cycle pulse when the result is valid.
REQ-008 SHALL have port: multdiv_result  output  32  signed result (product low word or quotient).
REQ-009 SHALL have port: multdiv_exception  output  1  overflow or divide-by-zero flag for the completed operation.
REQ-010 SHALL have port: multdiv_rd  output  5  destination register of the completed operation.

Function
REQ-011 SHALL decode start = (opcode == 00000) and (ALU op == 00110 mult or 00111 div), combinationally from dx_ir_in.
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 SHALL, on the clock edge ending a start cycle in IDLE or DONE: latch operand_a, operand_b, rd, and op kind; clear the iteration counter; enter BUSY.
REQ-014 SHALL ignore start while in BUSY; latched operands, rd, and counter are unaffected.
REQ-015 SHALL perform one iteration per cycle in BUSY using radix-2 shift-add multiply or restoring divide on magnitudes, with the 5-bit counter running 0..31.
REQ-016 SHALL leave BUSY for DONE on the edge where counter == 31; BUSY therefore lasts exactly 32 cycles.
REQ-017 SHALL assert multdiv_is_running registered, exactly when state == BUSY.
REQ-018 SHALL assert multdiv_result_ready exactly when state == DONE, for one cycle; DONE returns to IDLE unless start is present.
REQ-019 SHALL set the start-to-ready latency to 33 edges (start cycle N, ready in cycle N+33).
REQ-020 SHALL hold multdiv_result, multdiv_exception, and multdiv_rd stable from DONE until the next DONE.
REQ-021 SHALL compute mult results as the low 32 bits of the 64-bit signed product; exception = 1 when product[63:31] is not all-equal.
REQ-022 SHALL compute div results as the signed quotient truncated toward zero; remainder is discarded.
REQ-023 SHALL set exception = 1 and result = 0 for div with operand_b == 0, still taking the full 32 cycles.
REQ-024 SHALL set exception = 1 and result = 0x80000000 for div of 0x80000000 by 0xFFFFFFFF.
REQ-025 SHALL apply the result sign as the XOR of the operand signs (div) or by product negation (mult) after the final iteration.

Reset
REQ-026 SHALL, on reset asserted in any state including mid-BUSY, force IDLE, counter 0, and all outputs 0 (running 0, ready 0, result 0x00000000, exception 0, rd 0).
REQ-027 SHALL discard any in-flight operation on reset; no ready pulse follows.
REQ-028 SHALL honour start in the first cycle after reset deassertion.

Structure
REQ-029 SHALL take the opcode constants (R-type 00000), ALU op codes (mult 00110, div 00111), the iteration count 32, and the state encoding from the shared processor package.
REQ-030 SHALL place the shift/add/subtract datapath in one sub-module, multdiv_iter_core; the FSM, counter, decode, and sign/exception logic stay in multdiv_sequencer.

Verification
REQ-031 SHALL cover: mult 7 x -3 at cycle N -> running cycles N+1..N+32, ready at N+33, result 0xFFFFFFEB, exception 0, rd as issued.
REQ-032 SHALL cover: div -100 / 7 -> result 0xFFFFFFF2 (-14), exception 0, 33-edge latency.
REQ-033 SHALL cover: div 5 / 0 -> result 0, exception 1, ready still at N+33; mult 0x10000 x 0x10000 -> result 0, exception 1.
REQ-034 SHALL cover: second start held on dx_ir_in during BUSY -> ignored; a start during DONE -> running again next cycle, previous result intact on the ready cycle.
REQ-035 SHALL cover: reset asserted at BUSY counter 15 -> all outputs 0 immediately; no ready pulse; a new mult afterwards completes normally.
